// File: rtl/wb_resp_pkg.sv
// wb_resp_pkg
//   Shared definitions for the Wishbone SDRAM-emulation responder:
//   FSM state encoding, latency counter width and the default window base.
package wb_resp_pkg;

  // Latency counter width; covers programmable latencies 0..255.
  localparam int LAT_W = 8;

  // Default byte base of the user-area SDRAM window.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3800_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/wb_resp_ram.sv
// wb_resp_ram
//   Single-port 32-bit RAM with four byte-lane write enables and a
//   synchronous (registered) read port. Contents are never cleared.
// Ports
//   clk    in   1        clock
//   en     in   1        access enable (read or write this edge)
//   we     in   1        1 = write, 0 = read
//   be     in   4        byte-lane enables, bit n -> data[8n+7:8n]
//   addr   in   ADDR_W   word index
//   wdata  in   32       write data
//   rdata  out  32       read data, valid the cycle after a read access
module wb_resp_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_mem_responder.sv
// wb_mem_responder
//   Wishbone classic slave emulating the user-area SDRAM behind the DMA
//   arbiter. Each single read/write cycle waits a programmable latency and
//   then completes with a one-cycle registered ack.
// Ports
//   wb_clk_i   in   1   clock
//   wb_rst_i   in   1   reset, asynchronous, active-high
//   wbs_stb_i  in   1   strobe
//   wbs_cyc_i  in   1   cycle valid
//   wbs_we_i   in   1   1 = write
//   wbs_sel_i  in   4   byte-lane enables
//   wbs_dat_i  in   32  write data
//   wbs_adr_i  in   32  byte address
//   wbs_ack_o  out  1   transfer complete, one-cycle pulse
//   wbs_dat_o  out  32  read data, valid while wbs_ack_o high, then held
//   wbs_err_o  out  1   window-miss error
// Configuration
//   WB_RESP_ERR_EN  defined: a window miss pulses wbs_err_o instead of ack.
//                   undefined: wbs_err_o tied 0, misses ack with read data 0
//                   and writes dropped.
module wb_mem_responder
  import wb_resp_pkg::*;
#(
  parameter int          pADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          RD_LAT      = 10,
  parameter int          WR_LAT      = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_err_o
);

  resp_state_e            state;
  logic [LAT_W-1:0]       cnt;
  logic [31:2]            adr_q;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [31:0]            wdat_q;
  logic [31:0]            rd_hold;
  logic [31:0]            ram_rdata;
  logic [pADDR_WIDTH-1:0] ram_idx;
  logic                   req;
  logic                   hit;
  logic                   last_wait;
  logic                   ram_en;

  // Byte offset within a word has no meaning for a 32-bit-only responder.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  assign req       = wbs_stb_i & wbs_cyc_i;
  assign hit       = (adr_q[31:pADDR_WIDTH+2] == BASE_ADDR[31:pADDR_WIDTH+2]);
  assign ram_idx   = adr_q[pADDR_WIDTH+1:2];

  // The edge that moves WAIT -> RESP is the single RAM access edge: writes
  // commit there and reads launch there so data is ready during RESP.
  assign last_wait = (state == WAIT) && req && (cnt == '0);
  assign ram_en    = last_wait && hit;

  wb_resp_ram #(
    .ADDR_W (pADDR_WIDTH)
  ) u_ram (
    .clk   (wb_clk_i),
    .en    (ram_en),
    .we    (we_q),
    .be    (sel_q),
    .addr  (ram_idx),
    .wdata (wdat_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdat_q    <= '0;
      rd_hold   <= '0;
      wbs_ack_o <= 1'b0;
`ifdef WB_RESP_ERR_EN
      wbs_err_o <= 1'b0;
`endif
    end else begin
      wbs_ack_o <= 1'b0;
`ifdef WB_RESP_ERR_EN
      wbs_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            adr_q  <= wbs_adr_i[31:2];
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            wdat_q <= wbs_dat_i;
            cnt    <= wbs_we_i ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);
            state  <= WAIT;
          end
        end
        WAIT: begin
          // A master withdrawing stb/cyc abandons the access entirely.
          if (!req) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= RESP;
`ifdef WB_RESP_ERR_EN
            if (hit) begin
              wbs_ack_o <= 1'b1;
            end else begin
              wbs_err_o <= 1'b1;
            end
`else
            wbs_ack_o <= 1'b1;
`endif
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        RESP: begin
          // Capture the returned word so wbs_dat_o holds it after the ack.
          if (!we_q) begin
            if (hit) begin
              rd_hold <= ram_rdata;
            end
`ifndef WB_RESP_ERR_EN
            else begin
              rd_hold <= '0;
            end
`endif
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef WB_RESP_ERR_EN
  assign wbs_err_o = 1'b0;
`endif

  // During a read RESP the RAM output is presented directly (it was
  // registered on the RESP entry edge); otherwise the held word is shown.
  always_comb begin
    wbs_dat_o = rd_hold;
    if (state == RESP && !we_q) begin
      if (hit) begin
        wbs_dat_o = ram_rdata;
      end
`ifndef WB_RESP_ERR_EN
      else begin
        wbs_dat_o = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

  localparam int RD_LAT = 10;
  localparam int WR_LAT = 4;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbs_err_o;

  int checks = 0;
  int errors = 0;

  wb_mem_responder #(
    .pADDR_WIDTH (10),
    .BASE_ADDR   (32'h3800_0000),
    .RD_LAT      (RD_LAT),
    .WR_LAT      (WR_LAT)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_err_o (wbs_err_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Bus driver: called at a negedge, raises stb/cyc, waits (bounded) for
  // ack or err, drops the request, then samples one more cycle so the
  // caller can confirm the response was a single-cycle pulse.
  // lat = posedges after the first sampling edge until the response.
  task automatic do_txn(input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output int lat, output logic saw_ack,
                        output logic saw_err, output logic [31:0] rd,
                        output logic extra);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
    lat = -1;
    saw_ack = 1'b0;
    saw_err = 1'b0;
    rd = '0;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o || wbs_err_o) begin
        lat     = n - 1;
        saw_ack = wbs_ack_o;
        saw_err = wbs_err_o;
        rd      = wbs_dat_o;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    extra = wbs_ack_o | wbs_err_o;
  endtask

  task automatic test_reset();
    wb_rst_i  = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_dat_i = '0;
    wbs_adr_i = '0;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (wbs_ack_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ack: got %b expected 0", wbs_ack_o);
    end
    checks++;
    if (wbs_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err: got %b expected 0", wbs_err_o);
    end
    checks++;
    if (wbs_dat_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_dat: got %h expected 00000000", wbs_dat_o);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic test_write();
    int lat;
    logic a, e, x;
    logic [31:0] rd;
    do_txn(1'b1, 32'h3800_0004, 4'hF, 32'hDEAD_BEEF, lat, a, e, rd, x);
    checks++;
    if (lat != WR_LAT + 1 || a !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_ack: got lat %0d ack %b err %b expected lat %0d ack 1 err 0",
               lat, a, e, WR_LAT + 1);
    end
    checks++;
    if (x !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_ack_width: got second-cycle ack %b expected 0", x);
    end
  endtask

  task automatic test_read();
    int lat;
    logic a, e, x;
    logic [31:0] rd;
    do_txn(1'b0, 32'h3800_0004, 4'hF, 32'h0, lat, a, e, rd, x);
    checks++;
    if (lat != RD_LAT + 1 || a !== 1'b1 || x !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_ack: got lat %0d ack %b extra %b expected lat %0d ack 1 extra 0",
               lat, a, x, RD_LAT + 1);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL read_data: got %h expected deadbeef", rd);
    end
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (wbs_dat_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL read_data_hold: got %h expected deadbeef", wbs_dat_o);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic a, e, x;
    logic [31:0] rd;
    do_txn(1'b1, 32'h3800_0004, 4'b0101, 32'h1234_5678, lat, a, e, rd, x);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lane_write_ack: got %b expected 1", a);
    end
    do_txn(1'b0, 32'h3800_0004, 4'hF, 32'h0, lat, a, e, rd, x);
    checks++;
    if (rd !== 32'hDE34_BE78) begin
      errors++;
      $display("[TB] FAIL lane_readback: got %h expected de34be78", rd);
    end
  endtask

  task automatic test_abort();
    int lat;
    int acks;
    logic a, e, x;
    logic [31:0] rd;
    do_txn(1'b1, 32'h3800_0008, 4'hF, 32'hCAFE_F00D, lat, a, e, rd, x);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = 32'h3800_0008;
    wbs_sel_i = 4'hF;
    wbs_dat_i = 32'h1111_1111;
    repeat (2) @(negedge wb_clk_i);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    acks = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o || wbs_err_o) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_ack: got %0d responses expected 0", acks);
    end
    do_txn(1'b0, 32'h3800_0008, 4'hF, 32'h0, lat, a, e, rd, x);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL abort_readback: got %h expected cafef00d", rd);
    end
  endtask

  task automatic test_window_miss();
    int lat;
    logic a, e, x;
    logic [31:0] rd;
    do_txn(1'b0, 32'h3000_0000, 4'hF, 32'h0, lat, a, e, rd, x);
`ifdef WB_RESP_ERR_EN
    checks++;
    if (lat != RD_LAT + 1 || a !== 1'b0 || e !== 1'b1) begin
      errors++;
      $display("[TB] FAIL miss_read_err: got lat %0d ack %b err %b expected lat %0d ack 0 err 1",
               lat, a, e, RD_LAT + 1);
    end
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL miss_read_dat: got %h expected cafef00d", rd);
    end
`else
    checks++;
    if (lat != RD_LAT + 1 || a !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL miss_read_ack: got lat %0d ack %b err %b expected lat %0d ack 1 err 0",
               lat, a, e, RD_LAT + 1);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL miss_read_dat: got %h expected 00000000", rd);
    end
`endif
    // Aliases word index 1 outside the window; must not touch RAM.
    do_txn(1'b1, 32'h3000_0004, 4'hF, 32'hFFFF_FFFF, lat, a, e, rd, x);
    do_txn(1'b0, 32'h3800_0004, 4'hF, 32'h0, lat, a, e, rd, x);
    checks++;
    if (rd !== 32'hDE34_BE78) begin
      errors++;
      $display("[TB] FAIL miss_write_dropped: got %h expected de34be78", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int acks;
    int last;
    int cyc_n;
    int late;
    logic a, e, x;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b1, 32'h3800_0040 + 32'(4 * i), 4'hF, 32'hA500_0000 | 32'(i),
             lat, a, e, rd, x);
    end
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3800_0040;
    acks  = 0;
    last  = 0;
    cyc_n = 0;
    while (acks < 16 && cyc_n < 1000) begin
      @(negedge wb_clk_i);
      cyc_n++;
      if (wbs_ack_o) begin
        checks++;
        if (wbs_dat_o !== (32'hA500_0000 | 32'(acks))) begin
          errors++;
          $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", acks, wbs_dat_o,
                   32'hA500_0000 | 32'(acks));
        end
        if (acks > 0) begin
          checks++;
          if (cyc_n - last != RD_LAT + 3) begin
            errors++;
            $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", acks,
                     cyc_n - last, RD_LAT + 3);
          end
        end
        last = cyc_n;
        acks++;
        wbs_adr_i = 32'h3800_0040 + 32'(4 * acks);
      end
    end
    checks++;
    if (acks != 16) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected 16", acks);
    end
    // Request 17 is now in WAIT; reset must kill it immediately.
    repeat (5) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_in_wait: got ack %b dat %h expected ack 0 dat 00000000",
               wbs_ack_o, wbs_dat_o);
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    late = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o || wbs_err_o) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %0d responses after reset expected 0", late);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_byte_lanes();
    test_abort();
    test_window_miss();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
